// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity (UART_TX_PARITY_EN), stop bit(s).
// tx falls one cycle after accept; tx_ready is low for the whole frame and new bytes wait at the source.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          baud_q;
  logic [CW-1:0]          baud_d;
  logic [2:0]             bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   shift_d;
  logic                   tx_q;
  logic                   rdy_q;
  logic                   baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  assign baud_wrap = (baud_q == BAUD_LAST);
  assign baud_d    = (state_q == S_IDLE || baud_wrap) ? '0 : baud_q + CW'(1);
  assign shift_d   = shift_q >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      baud_q <= baud_d;
      case (state_q)
        S_IDLE: begin
          if (tx_valid && rdy_q) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
            rdy_q   <= 1'b0;
            shift_q <= tx_data[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
            par_q   <= (^tx_data[DATA_BITS-1:0]) ^ 1'(PARITY_ODD);
`endif
          end
        end
        S_START: begin
          if (baud_wrap) begin
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end
        end
        S_DATA: begin
          if (baud_wrap) begin
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_d;
              tx_q    <= shift_d[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_wrap) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          // bit counter is idle here, so it marks the first of two stop bits
          if (baud_wrap) begin
            if (STOP_BITS == 2 && bit_q == 3'd0) begin
              bit_q <= 3'd1;
            end else begin
              bit_q   <= '0;
              state_q <= S_IDLE;
              rdy_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = rdy_q;
  assign tx_busy  = ~rdy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit; parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  int      errors = 0;
  int      checks = 0;
  int      acc_cnt = 0;
  longint  acc_t = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy)
  );

`ifdef UART_TX_PARITY_EN
  logic [7:0] o_data = 8'h00;
  logic       o_valid = 1'b0;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(o_data), .tx_valid(o_valid),
    .tx_ready(o_ready), .tx(o_tx), .tx_busy(o_busy)
  );
`endif

  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      acc_cnt++;
      acc_t = $time;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(input string tag);
    int c0;
    bit got;
    c0  = acc_cnt;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != c0) got = 1'b1;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  // Bit 0 = start bit, then data LSB first, [parity], stop bit.
  function automatic logic [15:0] frame_of(input logic [7:0] d, input logic par);
`ifdef UART_TX_PARITY_EN
    return {5'b0, 1'b1, par, d, 1'b0};
`else
    return {6'b0, 1'b1, d, 1'b0} | {15'b0, par & 1'b0};
`endif
  endfunction

  // Called just after the accept edge; returns on the first idle cycle after the frame.
  task automatic frame_check(input string tag, input logic [15:0] exp_bits);
    logic [15:0] bits;
    logic        first_tx;
    logic        busy_ok;
    int          lowcnt;
    bits     = '0;
    first_tx = 1'bx;
    busy_ok  = 1'b1;
    lowcnt   = 0;
    for (int c = 0; c < F; c++) begin
      @(negedge clk);
      if (c == 0) first_tx = tx;
      if (c % CPB == CPB / 2) bits[c / CPB] = tx;
      if (tx_ready === 1'b0) lowcnt++;
      if (tx_busy !== ~tx_ready) busy_ok = 1'b0;
    end
    @(negedge clk);
    if (tx_busy !== ~tx_ready) busy_ok = 1'b0;
    chk({tag, "_bits"}, 32'(bits), 32'(exp_bits));
    chk({tag, "_fall"}, 32'(first_tx), 32'd0);
    chk({tag, "_rdy_low_cycles"}, 32'(lowcnt), 32'(F));
    chk({tag, "_busy_eq_not_rdy"}, 32'(busy_ok), 32'd1);
    chk({tag, "_end_rdy"}, 32'(tx_ready), 32'd1);
    chk({tag, "_end_tx_idle"}, 32'(tx), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic   ok;
    longint t1;
    int     c0;

    // Reset state
    #1 rst_n = 1'b0;
    #8;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
    end
    chk("idle_hold", 32'(ok), 32'd1);
    chk("idle_no_accept", 32'(acc_cnt), 32'd0);

    // Single byte 0xA5
    @(posedge clk);
    #1 tx_data = 8'hA5;
    tx_valid = 1'b1;
    wait_accept("acc_a5");
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    frame_check("a5", frame_of(8'hA5, 1'b0));

    // Back-to-back 0x00 then 0xFF with valid held
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    wait_accept("acc_00");
    t1      = acc_t;
    tx_data = 8'hFF;
    frame_check("b2b_00", frame_of(8'h00, 1'b0));
    wait_accept("acc_ff");
    chk("b2b_gap_cycles", 32'((acc_t - t1) / 10), 32'(F + 1));
    tx_valid = 1'b0;
    frame_check("b2b_ff", frame_of(8'hFF, 1'b0));

    // Data stability after accept and ignored mid-frame valid pulse
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    wait_accept("acc_81");
    c0       = acc_cnt;
    tx_valid = 1'b0;
    tx_data  = 8'h5A;
    fork
      frame_check("f81", frame_of(8'h81, 1'b0));
      begin
        repeat (12) @(posedge clk);
        #1 tx_data = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 tx_data = 8'hC3;
      end
    join
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1) ok = 1'b0;
    end
    chk("pulse_idle_after", 32'(ok), 32'd1);
    chk("pulse_no_accept", 32'(acc_cnt - c0), 32'd0);

    // Reset during data bit 3 (0xF0 has bit 3 low)
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    wait_accept("acc_f0");
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid_tx_before_rst", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_ready", 32'(tx_ready), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1) ok = 1'b0;
    end
    chk("post_rst_idle", 32'(ok), 32'd1);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    wait_accept("acc_55");
    tx_valid = 1'b0;
    frame_check("f55", frame_of(8'h55, 1'b0));

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07 is 1; odd-parity instance sends 0
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    wait_accept("acc_07");
    tx_valid = 1'b0;
    frame_check("par_even_07", frame_of(8'h07, 1'b1));
    o_data  = 8'h07;
    o_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("odd_busy", 32'(o_busy), 32'd1);
    o_valid = 1'b0;
    repeat (39) @(negedge clk);
    chk("odd_par_bit", 32'(o_tx), 32'd0);
    repeat (3) @(negedge clk);
    chk("odd_stop_bit", 32'(o_tx), 32'd1);
    repeat (4) @(negedge clk);
    chk("odd_end_ready", 32'(o_ready), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
